npg_channel_scheduler: RTL



---
 rtl/npg_channel_scheduler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/npg_channel_scheduler.sv
// Round-robin scheduler sharing one biphasic H-bridge/current-DAC output stage
// among NCH stimulation channels: LOAD, POS, PAUSE, NEG, optional GUARD.
module npg_channel_scheduler #(
    parameter int unsigned NCH = 4,
    parameter int unsigned GW  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [NCH-1:0]   req,
    input  logic [3*NCH-1:0] el1_flat,
    input  logic [3*NCH-1:0] el2_flat,
    input  logic [6*NCH-1:0] amp_flat,
    input  logic [2:0]       phaseDuration,
    input  logic [GW-1:0]    guard,
    input  logic             ovr_clr,
    output logic [2:0]       up_switches,
    output logic [2:0]       down_switches,
    output logic [5:0]       DAC,
    output logic [NCH-1:0]   grant,
    output logic [NCH-1:0]   done,
    output logic             busy,
    output logic [NCH-1:0]   overrun,
    output logic [NCH-1:0]   fault
);

    localparam int unsigned SW = $clog2(NCH);
    localparam int unsigned CW = (GW > 3) ? GW : 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        POS,
        PAUSE,
        NEG,
        GUARD
    } state_t;

    state_t state;
    state_t next_state;

    logic [NCH-1:0] pending;
    logic [SW-1:0]  rr_ptr;
    logic [SW-1:0]  sel;
    logic [SW-1:0]  sel_inc;
    logic [SW-1:0]  pick;
    logic [SW-1:0]  scan_idx;
    logic           pick_found;

    logic [2:0]     el1_l;
    logic [2:0]     el2_l;
    logic [5:0]     amp_l;
    logic [2:0]     el1_cur;
    logic [2:0]     el2_cur;
    logic [5:0]     amp_cur;
    logic [2:0]     plen;
    logic [2:0]     plen_in;
    logic [CW-1:0]  cnt;
    logic           cnt_zero;
    logic           conflict;
    logic           last_neg;
    logic           take;

    logic [NCH-1:0] clr_vec;
    logic [NCH-1:0] set_vec;
    logic [NCH-1:0] ovr_set;
    logic [NCH-1:0] flt_set;

    logic [2:0]     up_d;
    logic [2:0]     down_d;
    logic [5:0]     dac_d;
    logic [NCH-1:0] grant_d;
    logic [NCH-1:0] done_d;

    function automatic logic [NCH-1:0] onehot(input logic [SW-1:0] i);
        logic [NCH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First pending channel at or above rr_ptr, wrapping modulo NCH.
    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            scan_idx = SW'((32'(rr_ptr) + k) % NCH);
            if (!pick_found && pending[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
        end
    end

    // In LOAD the selected channel's inputs are used directly; afterwards the latched copy.
    always_comb begin
        el1_cur = el1_l;
        el2_cur = el2_l;
        amp_cur = amp_l;
        if (state == LOAD) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (sel == SW'(c)) begin
                    el1_cur = el1_flat[3*c +: 3];
                    el2_cur = el2_flat[3*c +: 3];
                    amp_cur = amp_flat[6*c +: 6];
                end
            end
        end
    end

    assign conflict = ((el1_cur & el2_cur) != 3'b000) || (el1_cur == 3'b000) || (el2_cur == 3'b000);
    assign cnt_zero = (cnt == '0);
    assign plen_in  = (phaseDuration == 3'd0) ? 3'd1 : phaseDuration;
    assign last_neg = (state == NEG) && cnt_zero;
    assign sel_inc  = (sel == SW'(NCH - 1)) ? '0 : sel + 1'b1;
    assign take     = (state == IDLE) && (next_state == LOAD);
    assign busy     = (state != IDLE);

    assign clr_vec  = take ? onehot(pick) : '0;
    assign set_vec  = enable ? req : '0;
    assign ovr_set  = set_vec & pending & ~clr_vec;
    assign flt_set  = (enable && (state == LOAD) && conflict) ? onehot(sel) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (pick_found) next_state = LOAD;
                LOAD:    next_state = conflict ? IDLE : POS;
                POS:     if (cnt_zero) next_state = PAUSE;
                PAUSE:   next_state = NEG;
                NEG:     if (cnt_zero) next_state = (guard != '0) ? GUARD : IDLE;
                GUARD:   if (cnt_zero) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output values are computed for the upcoming state so every output is a flop.
    always_comb begin
        up_d    = '0;
        down_d  = '0;
        dac_d   = '0;
        grant_d = '0;
        done_d  = '0;
        if (next_state != IDLE) begin
            grant_d = onehot((state == IDLE) ? pick : sel);
        end
        if (next_state == POS) begin
            up_d   = el1_cur;
            down_d = el2_cur;
            dac_d  = amp_cur;
        end else if (next_state == NEG) begin
            up_d   = el2_cur;
            down_d = el1_cur;
            dac_d  = amp_cur;
        end
        if (enable && last_neg) begin
            done_d = onehot(sel);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            overrun <= '0;
            fault   <= '0;
            rr_ptr  <= '0;
            sel     <= '0;
        end else begin
            pending <= enable ? ((pending & ~clr_vec) | set_vec) : '0;
            overrun <= (ovr_clr ? '0 : overrun) | ovr_set;
            fault   <= (ovr_clr ? '0 : fault) | flt_set;
            if (take) begin
                sel <= pick;
            end
            if (enable && (((state == LOAD) && conflict) || last_neg)) begin
                rr_ptr <= sel_inc;
            end
        end
    end

    // Phase counter reloads at PAUSE so NEG reuses the length captured on entry to POS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            el1_l <= '0;
            el2_l <= '0;
            amp_l <= '0;
            plen  <= 3'd1;
            cnt   <= '0;
        end else begin
            if (state == LOAD) begin
                el1_l <= el1_cur;
                el2_l <= el2_cur;
                amp_l <= amp_cur;
                plen  <= plen_in;
            end
            case (state)
                LOAD:       cnt <= CW'(plen_in - 3'd1);
                POS, GUARD: cnt <= cnt - 1'b1;
                PAUSE:      cnt <= CW'(plen - 3'd1);
                NEG:        cnt <= cnt_zero ? (CW'(guard) - 1'b1) : (cnt - 1'b1);
                default:    cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            up_switches   <= '0;
            down_switches <= '0;
            DAC           <= '0;
            grant         <= '0;
            done          <= '0;
        end else begin
            up_switches   <= up_d;
            down_switches <= down_d;
            DAC           <= dac_d;
            grant         <= grant_d;
            done          <= done_d;
        end
    end

endmodule
